// File: rtl/fft_input_buffer.sv
// Double-banked input buffer for a 32-point FFT: fills a write bank (optionally
// in bit-reversed slot order) and hands complete frames to Stage1 in parallel.
module fft_input_buffer #(
  parameter int p_inputBits  = 9,
  parameter int p_bitReverse = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          i_valid,
  input  logic signed [p_inputBits-1:0] i_sample,
  output logic                          o_ready,
  output logic                          o_frame_valid,
  input  logic                          i_frame_ack,
  output logic signed [p_inputBits-1:0] o_a0,  o_a1,  o_a2,  o_a3,
  output logic signed [p_inputBits-1:0] o_a4,  o_a5,  o_a6,  o_a7,
  output logic signed [p_inputBits-1:0] o_a8,  o_a9,  o_a10, o_a11,
  output logic signed [p_inputBits-1:0] o_a12, o_a13, o_a14, o_a15,
  output logic signed [p_inputBits-1:0] o_a16, o_a17, o_a18, o_a19,
  output logic signed [p_inputBits-1:0] o_a20, o_a21, o_a22, o_a23,
  output logic signed [p_inputBits-1:0] o_a24, o_a25, o_a26, o_a27,
  output logic signed [p_inputBits-1:0] o_a28, o_a29, o_a30, o_a31
);

  typedef enum logic {FILL = 1'b0, STALL = 1'b1} state_e;

  state_e                              state_q, state_d;
  logic [4:0]                          k_q, k_d;
  logic [31:0][p_inputBits-1:0]        wbank_q, wbank_d;
  logic [31:0][p_inputBits-1:0]        rbank_q, rbank_d;
  logic                                valid_q, valid_d;

  logic       accept, last, rd_free, swap;
  logic [4:0] slot;

  assign accept  = i_valid && o_ready;
  assign last    = accept && (k_q == 5'd31);
  assign rd_free = !valid_q || i_frame_ack;
  assign swap    = ((state_q == FILL) && last && rd_free) ||
                   ((state_q == STALL) && i_frame_ack);
  assign slot    = (p_bitReverse != 0) ? {k_q[0], k_q[1], k_q[2], k_q[3], k_q[4]} : k_q;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (last && !rd_free) state_d = STALL;
      STALL:   if (i_frame_ack)      state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    o_ready = (state_q == FILL) && !RST;
  end

  // The swap copies the write bank including the sample landing this cycle,
  // so the frame is visible one cycle after its 32nd sample.
  always_comb begin
    wbank_d = wbank_q;
    if (accept) wbank_d[slot] = i_sample;
    rbank_d = swap ? wbank_d : rbank_q;
    if (swap)                 k_d = 5'd0;
    else if (accept && !last) k_d = k_q + 5'd1;
    else                      k_d = k_q;
    if (swap)             valid_d = 1'b1;
    else if (i_frame_ack) valid_d = 1'b0;
    else                  valid_d = valid_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wbank_q <= '0;
      rbank_q <= '0;
      k_q     <= 5'd0;
      valid_q <= 1'b0;
    end else begin
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      k_q     <= k_d;
      valid_q <= valid_d;
    end
  end

  assign o_frame_valid = valid_q;

  assign o_a0  = rbank_q[0];   assign o_a1  = rbank_q[1];
  assign o_a2  = rbank_q[2];   assign o_a3  = rbank_q[3];
  assign o_a4  = rbank_q[4];   assign o_a5  = rbank_q[5];
  assign o_a6  = rbank_q[6];   assign o_a7  = rbank_q[7];
  assign o_a8  = rbank_q[8];   assign o_a9  = rbank_q[9];
  assign o_a10 = rbank_q[10];  assign o_a11 = rbank_q[11];
  assign o_a12 = rbank_q[12];  assign o_a13 = rbank_q[13];
  assign o_a14 = rbank_q[14];  assign o_a15 = rbank_q[15];
  assign o_a16 = rbank_q[16];  assign o_a17 = rbank_q[17];
  assign o_a18 = rbank_q[18];  assign o_a19 = rbank_q[19];
  assign o_a20 = rbank_q[20];  assign o_a21 = rbank_q[21];
  assign o_a22 = rbank_q[22];  assign o_a23 = rbank_q[23];
  assign o_a24 = rbank_q[24];  assign o_a25 = rbank_q[25];
  assign o_a26 = rbank_q[26];  assign o_a27 = rbank_q[27];
  assign o_a28 = rbank_q[28];  assign o_a29 = rbank_q[29];
  assign o_a30 = rbank_q[30];  assign o_a31 = rbank_q[31];

endmodule

// File: tb/tb_fft_input_buffer.sv
// Scoreboarded bench: bit-reversed and natural-order instances share stimulus;
// a frame-level reference model predicts each cycle's outputs.
module tb_fft_input_buffer;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             i_valid = 1'b0;
  logic       [8:0] i_sample = '0;
  logic             i_frame_ack = 1'b0;
  logic             rdy_br, rdy_nat, fv_br, fv_nat;
  logic [31:0][8:0] a_br, a_nat;

  always #5 CLK = ~CLK;

  fft_input_buffer #(.p_inputBits(9), .p_bitReverse(1)) u_br (
    .CLK(CLK), .RST(RST), .i_valid(i_valid), .i_sample(i_sample),
    .o_ready(rdy_br), .o_frame_valid(fv_br), .i_frame_ack(i_frame_ack),
    .o_a0(a_br[0]),   .o_a1(a_br[1]),   .o_a2(a_br[2]),   .o_a3(a_br[3]),
    .o_a4(a_br[4]),   .o_a5(a_br[5]),   .o_a6(a_br[6]),   .o_a7(a_br[7]),
    .o_a8(a_br[8]),   .o_a9(a_br[9]),   .o_a10(a_br[10]), .o_a11(a_br[11]),
    .o_a12(a_br[12]), .o_a13(a_br[13]), .o_a14(a_br[14]), .o_a15(a_br[15]),
    .o_a16(a_br[16]), .o_a17(a_br[17]), .o_a18(a_br[18]), .o_a19(a_br[19]),
    .o_a20(a_br[20]), .o_a21(a_br[21]), .o_a22(a_br[22]), .o_a23(a_br[23]),
    .o_a24(a_br[24]), .o_a25(a_br[25]), .o_a26(a_br[26]), .o_a27(a_br[27]),
    .o_a28(a_br[28]), .o_a29(a_br[29]), .o_a30(a_br[30]), .o_a31(a_br[31])
  );

  fft_input_buffer #(.p_inputBits(9), .p_bitReverse(0)) u_nat (
    .CLK(CLK), .RST(RST), .i_valid(i_valid), .i_sample(i_sample),
    .o_ready(rdy_nat), .o_frame_valid(fv_nat), .i_frame_ack(i_frame_ack),
    .o_a0(a_nat[0]),   .o_a1(a_nat[1]),   .o_a2(a_nat[2]),   .o_a3(a_nat[3]),
    .o_a4(a_nat[4]),   .o_a5(a_nat[5]),   .o_a6(a_nat[6]),   .o_a7(a_nat[7]),
    .o_a8(a_nat[8]),   .o_a9(a_nat[9]),   .o_a10(a_nat[10]), .o_a11(a_nat[11]),
    .o_a12(a_nat[12]), .o_a13(a_nat[13]), .o_a14(a_nat[14]), .o_a15(a_nat[15]),
    .o_a16(a_nat[16]), .o_a17(a_nat[17]), .o_a18(a_nat[18]), .o_a19(a_nat[19]),
    .o_a20(a_nat[20]), .o_a21(a_nat[21]), .o_a22(a_nat[22]), .o_a23(a_nat[23]),
    .o_a24(a_nat[24]), .o_a25(a_nat[25]), .o_a26(a_nat[26]), .o_a27(a_nat[27]),
    .o_a28(a_nat[28]), .o_a29(a_nat[29]), .o_a30(a_nat[30]), .o_a31(a_nat[31])
  );

  typedef struct packed {
    logic             v;
    logic             r;
    logic [31:0][8:0] f;   // f[k] = k-th sample of the presented frame
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: samples gathered per frame, one pending full frame when stalled.
  logic [8:0]       m_fill[$];
  logic [31:0][8:0] m_pres = '0;
  logic [31:0][8:0] m_full = '0;
  bit               m_valid = 0;
  bit               m_stall = 0;

  function automatic int brv(input int k);
    int r = 0;
    for (int b = 0; b < 5; b++) if (k[b]) r = r | (1 << (4 - b));
    return r;
  endfunction

  task automatic chk1(input string n, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b expected %b", n, $time, act, exp);
    end
  endtask

  task automatic chkf(input string n, input logic [31:0][8:0] act, input logic [31:0][8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      for (int i = 0; i < 32; i++)
        if (act[i] !== exp[i]) begin
          $display("FAIL %s at %0t: o_a%0d got %0d expected %0d", n, $time, i,
                   $signed(act[i]), $signed(exp[i]));
          break;
        end
    end
  endtask

  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t             e;
      logic [31:0][8:0] eb;
      e = sb.pop_front();
      for (int k = 0; k < 32; k++) eb[brv(k)] = e.f[k];
      chk1("valid_br",  fv_br,   e.v);
      chk1("valid_nat", fv_nat,  e.v);
      chk1("ready_br",  rdy_br,  e.r);
      chk1("ready_nat", rdy_nat, e.r);
      chkf("frame_br",  a_br,    eb);
      chkf("frame_nat", a_nat,   e.f);
    end
  end

  // One clock of stimulus: record what the DUT should show this cycle, then
  // advance the model across the closing edge.
  task automatic cyc(input logic v, input logic [8:0] s, input logic a, input logic r,
                     output bit acc);
    exp_t             e;
    logic [31:0][8:0] fr;
    bit               done;
    @(posedge CLK);
    #1;
    RST = r; i_valid = v; i_sample = s; i_frame_ack = a;
    e.v = m_valid; e.r = !r && !m_stall; e.f = m_pres;
    sb.push_back(e);
    acc = 0; done = 0;
    if (r) begin
      m_fill.delete(); m_stall = 0; m_valid = 0; m_pres = '0;
    end else if (m_stall) begin
      if (a) begin m_pres = m_full; m_stall = 0; end
    end else begin
      if (v) begin
        acc = 1;
        m_fill.push_back(s);
        if (m_fill.size() == 32) begin
          for (int i = 0; i < 32; i++) fr[i] = m_fill[i];
          m_fill.delete();
          done = 1;
          if (!m_valid || a) begin m_pres = fr; m_valid = 1; end
          else begin m_full = fr; m_stall = 1; end
        end
      end
      if (!done && a) m_valid = 0;
    end
  endtask

  // mode: 0 ramp, 1 all -1, 2 alternating -256/+255, 3 random, 4 all 7
  // ackm: 0 never, 1 on the 32nd sample, 2 random
  task automatic send_frame(input int mode, input int ackm, input int gap);
    int         n = 0;
    int         guard = 0;
    bit         acc;
    logic       v, a;
    logic [8:0] s;
    while (n < 32) begin
      v = ($urandom_range(99) >= gap);
      case (mode)
        0:       s = 9'(n);
        1:       s = 9'h1FF;
        2:       s = n[0] ? 9'h0FF : 9'h100;
        4:       s = 9'd7;
        default: s = 9'($urandom);
      endcase
      if (ackm == 1)      a = v && (n == 31);
      else if (ackm == 2) a = ($urandom_range(3) == 0);
      else                a = 1'b0;
      cyc(v, s, a, 1'b0, acc);
      if (acc) n++;
      guard++;
      if (guard > 2000) begin
        total++; bad++;
        $display("FAIL send_frame_bound: frame stuck at sample %0d expected 32", n);
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    repeat (3) cyc(1'b1, 9'd3, 1'b0, 1'b1, acc);
    repeat (3) cyc(1'b0, 9'd0, 1'b1, 1'b0, acc);   // stray ack with nothing presented
    send_frame(0, 0, 0);                          // ramp
    repeat (2) cyc(1'b0, 9'd0, 1'b0, 1'b0, acc);
    send_frame(1, 0, 0);                          // -1 frame stalls behind ramp
    repeat (3) cyc(1'b1, 9'd5, 1'b0, 1'b0, acc);
    cyc(1'b0, 9'd0, 1'b1, 1'b0, acc);
    send_frame(3, 1, 0);                          // zero-bubble swap
    send_frame(2, 1, 20);                         // extremes
    for (int i = 0; i < 17; i++) cyc(1'b1, 9'($urandom), 1'b0, 1'b0, acc);
    repeat (2) cyc(1'b1, 9'd9, 1'b0, 1'b1, acc);
    send_frame(4, 0, 0);                          // sevens after mid-frame reset
    repeat (2) cyc(1'b0, 9'd0, 1'b0, 1'b0, acc);
    for (int f = 0; f < 24; f++) begin
      if ($urandom_range(7) == 0) begin
        repeat ($urandom_range(30)) cyc(1'b1, 9'($urandom), 1'b0, 1'b0, acc);
        cyc(1'b0, 9'd0, 1'b0, 1'b1, acc);
      end
      send_frame(3, 2, 30);
    end
    repeat (4) cyc(1'b0, 9'd0, 1'b1, 1'b0, acc);
    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge CLK);
    @(posedge CLK);
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: %0d expectations left expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_input_buffer.md
FFT_INPUT_BUFFER -- requirements
Module: fft_input_buffer

Interface
REQ-001 Parameter p_inputBits, default 9: width of one signed real sample.
REQ-002 Parameter p_bitReverse, default 1: 1 = store in bit-reversed slot order; 0 = natural order.
REQ-003 CLK  input  1  Single clock; all state updates on its rising edge.
REQ-004 RST  input  1  Reset, synchronous and active-high.
REQ-005 i_valid  input  1  Upstream sample valid.
REQ-006 i_sample  input  p_inputBits  Signed real time-domain sample.
REQ-007 o_ready  output  1  Buffer accepts a sample this cycle.
REQ-008 o_frame_valid  output  1  o_a0..o_a31 hold a complete 32-sample frame.
REQ-009 i_frame_ack  input  1  Downstream Stage1 has consumed the presented frame.
REQ-010 o_a0 .. o_a31  output  p_inputBits each  Parallel signed frame to Stage1 inputs i_a0..i_a31.

Function
REQ-011 The block SHALL hold two 32-entry register banks: a write bank (filling) and a read bank (driving o_a0..o_a31).
REQ-012 A sample SHALL be accepted only on a cycle where i_valid=1 and o_ready=1.
REQ-013 A 5-bit write counter k SHALL start at 0 and increment by 1 per accepted sample.
REQ-014 Accepted sample k SHALL be written to write-bank slot bitrev5(k) when p_bitReverse=1, or to slot k when p_bitReverse=0 (e.g. k=1 -> slot 16, k=3 -> slot 24).
REQ-015 The state machine SHALL have two states: FILL (o_ready=1) and STALL (o_ready=0).
REQ-016 In FILL, the 32nd sample (k=31) SHALL be accepted at cycle t.
- If the read bank is free at cycle t (o_frame_valid=0, or i_frame_ack=1 that cycle), the banks SHALL swap at t+1.
- Otherwise the block SHALL enter STALL at t+1.
REQ-017 A bank swap SHALL make o_a0..o_a31 present the completed frame, set o_frame_valid=1, reset k to 0, and return to or remain in FILL.
REQ-018 Latency SHALL be exactly 1 cycle from acceptance of the 32nd sample to o_frame_valid=1 with that frame's data, when no stall occurs.
REQ-019 In STALL, i_frame_ack=1 at cycle t SHALL cause a swap at t+1; o_ready SHALL be 1 and o_frame_valid SHALL remain 1 (new frame) at t+1.
REQ-020 i_frame_ack=1 in FILL with no frame completing SHALL clear o_frame_valid at the next cycle.
REQ-021 i_frame_ack SHALL be ignored while o_frame_valid=0.
REQ-022 o_a0..o_a31 SHALL remain stable while o_frame_valid=1 and no swap occurs, regardless of write activity.
REQ-023 Simultaneous 32nd-sample acceptance and i_frame_ack SHALL swap with no bubble: o_frame_valid stays 1 and the new frame appears at t+1.
REQ-024 Samples SHALL be stored bit-exact, with no sign extension, rounding or saturation.
REQ-025 The write counter SHALL wrap from 31 to 0 only via a swap; it SHALL never advance in STALL.

Reset
REQ-026 RST=1 at a rising edge SHALL clear both banks to 0, set k=0, state=FILL, o_frame_valid=0, and o_a0..o_a31=0.
REQ-027 o_ready SHALL be 0 during any cycle where RST=1, and 1 on the first cycle after RST deasserts.
REQ-028 Reset mid-frame SHALL discard all partially written and presented data; the next accepted sample SHALL be k=0.

Verification
REQ-029 Ramp test: feed samples 0..31 back-to-back with i_frame_ack=0.
-> o_frame_valid=1 exactly 1 cycle after sample 31.
-> o_a0=0, o_a16=1, o_a8=2, o_a24=3, o_a31=31.
REQ-030 Backpressure: send a second 32-sample frame (values -1) with no ack.
-> o_ready=0 after its 32nd sample, o_a* unchanged.
-> Asserting ack gives o_a*=-1 the next cycle and o_ready=1.
REQ-031 Zero-bubble: ack on the same cycle as the 32nd sample of the next frame.
-> o_frame_valid stays 1 and the new data appears at t+1.
REQ-032 Extremes: samples alternating -256 and +255.
-> Values appear bit-exact at the bit-reversed positions.
REQ-033 Reset after 17 samples, then a full frame of 7s.
-> First valid frame is all 7s; o_frame_valid=0 and o_a*=0 during and immediately after reset.
REQ-034 Natural order with p_bitReverse=0, ramp input.
-> o_ak=k for all k.
-> Stray ack while o_frame_valid=0 has no effect.
